// File: rtl/omp_atom_select_if.sv
// omp_atom_select_if: request, BRAM and result signals of the OMP atom selector
// Ports (signals):
//   start, n_last, m_last, sel_mask      run request and its per-run configuration
//   phi_addr/phi_rdata, r_addr/r_rdata   Phi and residual BRAM read ports (1-cycle latency)
//   busy, done, found, lambda, max_abs   run status and selection result
// master: the side that requests runs and owns the BRAMs; slave: the selector.
interface omp_atom_select_if #(
    parameter int DW       = 16,
    parameter int MAX_COLS = 64,
    parameter int COL_W    = 6,
    parameter int ROW_W    = 5,
    parameter int ACC_W    = 40
);
    logic                    start;
    logic [COL_W-1:0]        n_last;
    logic [ROW_W-1:0]        m_last;
    logic [MAX_COLS-1:0]     sel_mask;
    logic [COL_W+ROW_W-1:0]  phi_addr;
    logic signed [DW-1:0]    phi_rdata;
    logic [ROW_W-1:0]        r_addr;
    logic signed [DW-1:0]    r_rdata;
    logic                    busy;
    logic                    done;
    logic                    found;
    logic [COL_W-1:0]        lambda;
    logic [ACC_W-1:0]        max_abs;

    modport master (
        output start, n_last, m_last, sel_mask, phi_rdata, r_rdata,
        input  phi_addr, r_addr, busy, done, found, lambda, max_abs
    );

    modport slave (
        input  start, n_last, m_last, sel_mask, phi_rdata, r_rdata,
        output phi_addr, r_addr, busy, done, found, lambda, max_abs
    );
endinterface

// File: rtl/omp_atom_select.sv
// omp_atom_select: picks the unmasked Phi column with the largest |<Phi_j, r>|
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; aborts a run without a done pulse
//   bus    omp_atom_select_if.slave: start/n_last/m_last/sel_mask request,
//          Phi and residual BRAM read ports, busy/done/found/lambda/max_abs result
module omp_atom_select #(
    parameter int DW       = 16,
    parameter int MAX_COLS = 64,
    parameter int COL_W    = 6,
    parameter int MAX_ROWS = 32,
    parameter int ROW_W    = 5,
    parameter int ACC_W    = 40
) (
    input logic               clk,
    input logic               rst_n,
    omp_atom_select_if.slave  bus
);
    if (2**COL_W < MAX_COLS || 2**ROW_W < MAX_ROWS || ACC_W < 2*DW+ROW_W+1) begin : g_bad_params
        $error("omp_atom_select: inconsistent width parameters");
    end

    typedef enum logic [2:0] {IDLE, CHK, ISSUE, FLUSH1, FLUSH2, CMP, DONE} state_t;

    state_t                 state;
    logic [COL_W-1:0]       j;
    logic [COL_W-1:0]       n_q;
    logic [COL_W-1:0]       best_idx;
    logic [ROW_W-1:0]       i;
    logic [ROW_W-1:0]       m_q;
    logic [MAX_COLS-1:0]    mask_q;
    logic                   v1;
    logic                   v2;
    logic                   found_int;
    logic signed [2*DW-1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-1:0]       best_abs;
    logic [ACC_W-1:0]       a;

    // ACC_W leaves headroom above the largest sum, so negating acc never wraps
    always_comb begin
        a = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            j            <= '0;
            n_q          <= '0;
            best_idx     <= '0;
            i            <= '0;
            m_q          <= '0;
            mask_q       <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            found_int    <= 1'b0;
            prod         <= '0;
            acc          <= '0;
            best_abs     <= '0;
            bus.phi_addr <= '0;
            bus.r_addr   <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.found    <= 1'b0;
            bus.lambda   <= '0;
            bus.max_abs  <= '0;
        end else begin
            bus.done <= 1'b0;
            // v1: BRAM data for an ISSUE address is on the read ports; v2: prod holds its product
            v1 <= (state == ISSUE);
            v2 <= v1;
            if (v1) prod <= bus.phi_rdata * bus.r_rdata;
            if (v2) acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= CHK;
                        bus.busy  <= 1'b1;
                        n_q       <= bus.n_last;
                        m_q       <= bus.m_last;
                        mask_q    <= bus.sel_mask;
                        j         <= '0;
                        best_abs  <= '0;
                        best_idx  <= '0;
                        found_int <= 1'b0;
                    end
                end
                CHK: begin
                    if (mask_q[j]) begin
                        if (j == n_q) state <= DONE;
                        else j <= j + 1'b1;
                    end else begin
                        acc          <= '0;
                        i            <= '0;
                        bus.phi_addr <= {j, ROW_W'(0)};
                        bus.r_addr   <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i == m_q) begin
                        state <= FLUSH1;
                    end else begin
                        i            <= i + 1'b1;
                        bus.phi_addr <= {j, ROW_W'(i + 1'b1)};
                        bus.r_addr   <= i + 1'b1;
                    end
                end
                FLUSH1: state <= FLUSH2;
                FLUSH2: state <= CMP;
                CMP: begin
                    // strict compare keeps the lowest index on ties
                    if (!found_int || a > best_abs) begin
                        best_abs  <= a;
                        best_idx  <= j;
                        found_int <= 1'b1;
                    end
                    if (j == n_q) state <= DONE;
                    else begin
                        j     <= j + 1'b1;
                        state <= CHK;
                    end
                end
                DONE: begin
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    bus.lambda  <= best_idx;
                    bus.max_abs <= best_abs;
                    bus.found   <= found_int;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/omp_atom_select.md
Name: omp_atom_select

Overview:
- Parametrised successor to the OMP-DRI block-A atom-selection path.
- Per OMP iteration it correlates the residual r against every active column of the measurement matrix Phi: corr_j = sum_i Phi[i][j]*r[i].
- It returns the index lambda of the largest |corr_j|, skipping atoms already chosen in earlier iterations.
- Run-time column count and residual length support every DRI resolution mode (4x4, 8x8, ...) from one instance; it sits between the residual/Phi BRAMs and the least-squares update stage.

Parameters:
- DW, 16, signed sample width of Phi and r entries.
- MAX_COLS, 64, maximum number of atoms (columns).
- COL_W, 6, column index width; must satisfy 2^COL_W >= MAX_COLS.
- MAX_ROWS, 32, maximum residual length.
- ROW_W, 5, row index width; must satisfy 2^ROW_W >= MAX_ROWS.
- ACC_W, 40, accumulator width; must satisfy ACC_W >= 2*DW+ROW_W+1, so no overflow is possible.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle request; honoured only in IDLE.
- n_last, input, COL_W, last active column index; 15 for 4x4, 63 for 8x8.
- m_last, input, ROW_W, last residual row index.
- sel_mask, input, MAX_COLS, bit j=1 excludes column j (already selected).
- phi_addr, output, COL_W+ROW_W, Phi BRAM address = {j,i}.
- phi_rdata, input, DW, Phi data; 1-cycle read latency.
- r_addr, output, ROW_W, residual BRAM address = i.
- r_rdata, input, DW, residual data; 1-cycle read latency.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when results are valid.
- found, output, 1, 1 if at least one unmasked column was evaluated.
- lambda, output, COL_W, winning column index.
- max_abs, output, ACC_W, |corr_lambda|, unsigned.

Behaviour:
- Reset: all outputs 0, addresses 0, FSM to IDLE. Reset asserted mid-run aborts immediately; no done pulse is produced.
- Sampling: n_last, m_last and sel_mask are captured at start acceptance. Later changes have no effect until the next run.
- start while busy or in DONE is ignored.
- FSM states: IDLE, CHK, ISSUE, FLUSH1, FLUSH2, CMP, DONE.
- IDLE -> CHK on start. Set j=0, clear best_abs=0, found_int=0, best_idx=0.
- CHK (1 cycle):
  - If sel_mask[j]=1: masked column, no BRAM reads. Go to CHK with j+1, or to DONE if j==n_last.
  - Otherwise clear acc and go to ISSUE with i=0.
- ISSUE (m_last+1 cycles): drive phi_addr={j,i}, r_addr=i, then i+1. Leave after i==m_last.
- Data pipeline: data returns one cycle after its address. The product phi_rdata*r_rdata (signed, 2*DW) is registered, then sign-extended into acc one cycle later.
- FLUSH1, FLUSH2: drain the last two pipeline stages.
- CMP (1 cycle): a = |acc| (ACC_W unsigned; the most-negative value is representable).
  - Update when found_int==0, or when a > best_abs (strict). Ties therefore keep the lowest index.
  - On update: best_abs=a, best_idx=j, found_int=1.
  - Then go to CHK with j+1, or to DONE if j==n_last.
- DONE (1 cycle): done=1, busy=0. lambda, max_abs and found are loaded from best_*, then the FSM returns to IDLE.
- Output hold: lambda, max_abs and found hold until the next DONE.
- Latency from start to the done pulse, in cycles:
  - Base: 1 + U*(m_last+5) + K, where U = number of unmasked columns in 0..n_last and K = number of masked ones.
  - Plus 1 for the DONE cycle.
- All masked: found=0, lambda=0, max_abs=0.
- n_last=0 and m_last=0 are legal: a single column, a single row.
- Address outputs hold their last value outside ISSUE.

Test Plan:
1. 4x4 mode: n_last=15, m_last=7, mask=0; Phi[i][j]=1 only where j==5, r=all 3 -> lambda=5, max_abs=24, found=1, done at cycle 1+16*12+1=194.
2. 8x8 mode: n_last=63, m_last=31, random Phi/r, mask=0 -> lambda and max_abs match the golden model; latency 1+64*36+1.
3. Mask and sign: same data as 1 but sel_mask[5]=1, column 9 holds -1 everywhere (corr=-24), column 2 holds corr=+24 -> tie resolved to lambda=2, max_abs=24; latency drops by 11 cycles.
4. All masked: n_last=15, sel_mask=16'hFFFF -> found=0, lambda=0, max_abs=0, done after 18 cycles, no BRAM address activity.
5. Robustness: pulse start again mid-run -> ignored; then assert rst_n=0 mid-run -> busy=0, done never pulses, and the next start runs cleanly.
6. Extreme values: Phi=r=-2^(DW-1) everywhere, m_last=31 -> max_abs=32*2^(2DW-2) with no overflow.
